// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight and
// buffers a single fetched instruction toward decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic        pc_sel,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        err_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        WAIT,
        DRAIN,
        ERR
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   ipc_q, ipc_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   tgt_pc;
    logic          timeout;
    logic          req;

    assign tgt_pc  = redirect_pc & ~32'h0000_0003;
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q & stall_i;
        err_d   = err_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        pc_sel  = 1'b1;

        if (state_q != ERR && redirect_i) begin
            pc_sel = 1'b0;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d = tgt_pc;
                end
            end

            FETCH: begin
                req = ~(vld_q & stall_i);
                if (redirect_i) begin
                    pc_d  = tgt_pc;
                    vld_d = 1'b0;
                end
                if (req && imem_ready) begin
                    cnt_d   = '0;
                    state_d = redirect_i ? DRAIN : WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                    if (redirect_i) begin
                        pc_d  = tgt_pc;
                        vld_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (redirect_i) begin
                        pc_d    = tgt_pc;
                        vld_d   = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end

            // Response here belongs to a squashed fetch; drop it.
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                    if (redirect_i) begin
                        pc_d  = tgt_pc;
                        vld_d = 1'b0;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (redirect_i) begin
                        pc_d  = tgt_pc;
                        vld_d = 1'b0;
                    end
                end
            end

            ERR: begin
                err_d = 1'b1;
                vld_d = 1'b0;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'h0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr_valid = vld_q;
    assign instr       = vld_q ? instr_q : NOP_INSTR;
    assign instr_pc    = ipc_q;
    assign err_o       = err_q;

endmodule
